// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one memory bus between instruction fetch and MEM-stage data, data first.
// Latency: bus_req_o rises one cycle after a request is seen in IDLE; results appear in RELEASE after ack.
// Backpressure: stallreq_o holds the pipeline until every owed access completes; bus waits on bus_ack_i.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   if_*              fetch request (level), address, returned instruction
//   mem_*             data request (level), we/sel/addr/wdata, returned read data
//   flush_i           pipeline flush; in-flight bus access completes but its result is dropped
//   stallreq_o        combinational stall request to ctrl
//   bus_*             registered single-master bus request, one-cycle ack strobe with read data
module mem_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_ce_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_data_o,
  input  logic          mem_ce_i,
  input  logic          mem_we_i,
  input  logic [3:0]    mem_sel_i,
  input  logic [AW-1:0] mem_addr_i,
  input  logic [DW-1:0] mem_data_i,
  output logic [DW-1:0] mem_data_o,
  input  logic          flush_i,
  output logic          stallreq_o,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [3:0]    bus_sel_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_wdata_o,
  input  logic          bus_ack_i,
  input  logic [DW-1:0] bus_rdata_i
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_D_BUSY  = 2'd1;
  localparam logic [1:0] S_I_BUSY  = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]    state_q,     state_d;
  logic          if_pend_q,   if_pend_d;
  logic          abort_q,     abort_d;
  logic          bus_req_q,   bus_req_d;
  logic          bus_we_q,    bus_we_d;
  logic [3:0]    bus_sel_q,   bus_sel_d;
  logic [AW-1:0] bus_addr_q,  bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic [DW-1:0] if_data_q,   if_data_d;
  logic [DW-1:0] mem_data_q,  mem_data_d;

  logic busy;
  logic abort_now;

  assign busy = (state_q == S_D_BUSY) || (state_q == S_I_BUSY);

  // A flush arriving in the very cycle of the ack must still discard the
  // result, so the registered abort is combined with the live flush.
  assign abort_now = abort_q | flush_i;

  always_comb begin
    state_d     = state_q;
    if_pend_d   = if_pend_q;
    abort_d     = abort_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_data_d   = if_data_q;
    mem_data_d  = mem_data_q;

    case (state_q)
      S_IDLE: begin
        abort_d   = 1'b0;
        if_pend_d = 1'b0;
        bus_req_d = 1'b0;
        // A flush in IDLE launches nothing; the redirected request is
        // picked up on a following cycle.
        if (!flush_i) begin
          if (mem_ce_i) begin
            bus_req_d   = 1'b1;
            bus_we_d    = mem_we_i;
            bus_sel_d   = mem_sel_i;
            bus_addr_d  = mem_addr_i;
            bus_wdata_d = mem_data_i;
            if_pend_d   = if_ce_i;
            state_d     = S_D_BUSY;
          end else if (if_ce_i) begin
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b0;
            bus_sel_d   = 4'b1111;
            bus_addr_d  = if_addr_i;
            bus_wdata_d = '0;
            state_d     = S_I_BUSY;
          end
        end
      end

      S_D_BUSY, S_I_BUSY: begin
        bus_req_d = 1'b1;
        if (flush_i) begin
          abort_d   = 1'b1;
          if_pend_d = 1'b0;
        end
        if (bus_ack_i) begin
          if ((state_q == S_D_BUSY) && if_pend_q && !abort_now) begin
            // Chain straight into the owed fetch without an IDLE cycle.
            if (!bus_we_q) begin
              mem_data_d = bus_rdata_i;
            end
            if_pend_d   = 1'b0;
            bus_we_d    = 1'b0;
            bus_sel_d   = 4'b1111;
            bus_addr_d  = if_addr_i;
            bus_wdata_d = '0;
            state_d     = S_I_BUSY;
          end else begin
            bus_req_d = 1'b0;
            if (abort_now) begin
              abort_d   = 1'b0;
              if_pend_d = 1'b0;
              state_d   = S_IDLE;
            end else begin
              if (state_q == S_I_BUSY) begin
                if_data_d = bus_rdata_i;
              end else if (!bus_we_q) begin
                mem_data_d = bus_rdata_i;
              end
              state_d = S_RELEASE;
            end
          end
        end
      end

      S_RELEASE: begin
        // The pipeline advances this cycle; requests still visible here are
        // the ones just served, so nothing is launched.
        bus_req_d = 1'b0;
        abort_d   = 1'b0;
        state_d   = S_IDLE;
      end

      default: begin
        bus_req_d = 1'b0;
        abort_d   = 1'b0;
        if_pend_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      if_pend_q   <= 1'b0;
      abort_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= 4'b0000;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_data_q   <= '0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      if_pend_q   <= if_pend_d;
      abort_q     <= abort_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_data_q   <= if_data_d;
      mem_data_q  <= mem_data_d;
    end
  end

  // Gated by rst so ctrl sees no stall while the block is held in reset,
  // even though the pipeline may still present requests.
  assign stallreq_o = rst
                    & (if_ce_i | mem_ce_i | busy)
                    & (state_q != S_RELEASE)
                    & ~((state_q == S_IDLE) & flush_i);

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign if_data_o   = if_data_q;
  assign mem_data_o  = mem_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        flush_i;
  logic        stallreq_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: architectural results visible to the pipeline.
  logic [31:0] exp_if_data;
  logic [31:0] exp_mem_data;
  logic [31:0] exp_bus_addr;

  mem_bus_arbiter #(.AW(32), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_ce_i    (if_ce_i),
    .if_addr_i  (if_addr_i),
    .if_data_o  (if_data_o),
    .mem_ce_i   (mem_ce_i),
    .mem_we_i   (mem_we_i),
    .mem_sel_i  (mem_sel_i),
    .mem_addr_i (mem_addr_i),
    .mem_data_i (mem_data_i),
    .mem_data_o (mem_data_o),
    .flush_i    (flush_i),
    .stallreq_o (stallreq_o),
    .bus_req_o  (bus_req_o),
    .bus_we_o   (bus_we_o),
    .bus_sel_o  (bus_sel_o),
    .bus_addr_o (bus_addr_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_ack_i  (bus_ack_i),
    .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  // One pipeline access group: optional data access and/or fetch, bus wait
  // states per access, optional flush during the data access (after which the
  // pipeline redirects the fetch to vaddr and drops the data request).
  // Starts and ends at a falling edge; returns after the RELEASE cycle.
  task automatic run_op(input bit do_mem, input bit mwe, input logic [3:0] msel,
                        input logic [31:0] maddr, input logic [31:0] mwdata,
                        input bit do_if, input logic [31:0] iaddr,
                        input int wd, input int wi, input int flush_at,
                        input logic [31:0] vaddr,
                        input logic [31:0] rd0, input logic [31:0] rd1,
                        input string name);
    logic [31:0] e_addr [2];
    bit          e_we   [2];
    logic [3:0]  e_sel  [2];
    logic [31:0] e_wd   [2];
    int          e_wait [2];
    logic [31:0] e_rd   [2];
    logic [31:0] a_addr [4];
    bit          a_we   [4];
    logic [3:0]  a_sel  [4];
    logic [31:0] a_wd   [4];
    logic [31:0] cur_addr, cur_wd, new_if, new_mem;
    logic [3:0]  cur_sel;
    logic        cur_we;
    int  n_exp, n_act, exp_stall, stall_cnt, unstable, idx, cnt;
    bit  flushing, flushed, in_txn, done;

    flushing = (flush_at >= 0);
    n_exp = 0;
    if (do_mem) begin
      e_addr[0] = maddr; e_we[0] = mwe; e_sel[0] = msel; e_wd[0] = mwdata;
      e_wait[0] = wd; e_rd[0] = rd0; n_exp = 1;
    end
    if (do_if) begin
      e_addr[n_exp] = flushing ? vaddr : iaddr;
      e_we[n_exp] = 1'b0; e_sel[n_exp] = 4'hF; e_wd[n_exp] = '0;
      e_wait[n_exp] = wi; e_rd[n_exp] = do_mem ? rd1 : rd0;
      n_exp = n_exp + 1;
    end
    // One IDLE cycle, every BUSY cycle, plus an extra IDLE after an aborted access.
    exp_stall = 1 + (flushing ? 1 : 0);
    for (int k = 0; k < n_exp; k++) exp_stall += e_wait[k] + 1;
    new_mem = (do_mem && !mwe && !flushing) ? rd0 : exp_mem_data;
    new_if  = do_if ? e_rd[n_exp-1] : exp_if_data;

    mem_ce_i = do_mem; mem_we_i = mwe; mem_sel_i = msel;
    mem_addr_i = maddr; mem_data_i = mwdata;
    if_ce_i = do_if; if_addr_i = iaddr;

    n_act = 0; stall_cnt = 0; unstable = 0; idx = 0; cnt = 0;
    flushed = 0; in_txn = 0; done = 0;
    cur_addr = '0; cur_wd = '0; cur_sel = '0; cur_we = 1'b0;

    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      flush_i = 1'b0;
      bus_ack_i = 1'b0;
      bus_rdata_i = $urandom;
      if (bus_req_o) begin
        if (!in_txn) begin
          cur_addr = bus_addr_o; cur_we = bus_we_o; cur_sel = bus_sel_o; cur_wd = bus_wdata_o;
          if (n_act < 4) begin
            a_addr[n_act] = bus_addr_o; a_we[n_act] = bus_we_o;
            a_sel[n_act] = bus_sel_o; a_wd[n_act] = bus_wdata_o;
          end
          n_act = n_act + 1;
          in_txn = 1; cnt = 0;
        end else if (bus_addr_o !== cur_addr || bus_we_o !== cur_we ||
                     bus_sel_o !== cur_sel || bus_wdata_o !== cur_wd) begin
          unstable = unstable + 1;
        end
        if (flushing && !flushed && idx == 0 && cnt == flush_at) begin
          flush_i = 1'b1; flushed = 1;
          mem_ce_i = 1'b0; if_addr_i = vaddr;
        end
        if (idx >= n_exp || cnt == e_wait[idx]) begin
          bus_ack_i = 1'b1;
          bus_rdata_i = (idx < n_exp) ? e_rd[idx] : $urandom;
          idx = idx + 1; in_txn = 0;
        end else begin
          cnt = cnt + 1;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        bus_ack_i = 1'b1;  // stray ack with no request outstanding
      end
      #1;
      if (stallreq_o) stall_cnt = stall_cnt + 1;
      else done = 1;
      if (!done) begin
        @(posedge clk);
        @(negedge clk);
      end
    end

    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL %s timeout: stall still %0b after 200 cycles, required release", name, stallreq_o);
    end
    n_vec++;
    if (stall_cnt !== exp_stall) begin
      n_err++;
      $display("FAIL %s stall_cycles: got %0d, expected %0d", name, stall_cnt, exp_stall);
    end
    n_vec++;
    if (n_act !== n_exp) begin
      n_err++;
      $display("FAIL %s bus_txn_count: got %0d, expected %0d", name, n_act, n_exp);
    end
    for (int k = 0; k < n_exp && k < n_act; k++) begin
      n_vec++;
      if (a_addr[k] !== e_addr[k] || a_we[k] !== e_we[k] || a_sel[k] !== e_sel[k] ||
          (e_we[k] && a_wd[k] !== e_wd[k])) begin
        n_err++;
        $display("FAIL %s bus_txn%0d: got addr=%h we=%0b sel=%h wd=%h, expected addr=%h we=%0b sel=%h wd=%h",
                 name, k, a_addr[k], a_we[k], a_sel[k], a_wd[k], e_addr[k], e_we[k], e_sel[k], e_wd[k]);
      end
    end
    n_vec++;
    if (unstable !== 0) begin
      n_err++;
      $display("FAIL %s bus_stable: %0d cycles changed while request held, expected 0", name, unstable);
    end
    n_vec++;
    if (bus_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s release_req: bus_req_o=%0b, expected 0", name, bus_req_o);
    end
    n_vec++;
    if (if_data_o !== new_if) begin
      n_err++;
      $display("FAIL %s if_data: got %h, expected %h", name, if_data_o, new_if);
    end
    n_vec++;
    if (mem_data_o !== new_mem) begin
      n_err++;
      $display("FAIL %s mem_data: got %h, expected %h", name, mem_data_o, new_mem);
    end
    exp_if_data = new_if;
    exp_mem_data = new_mem;
    if (n_exp > 0) exp_bus_addr = e_addr[n_exp-1];

    @(posedge clk);
    @(negedge clk);
    bus_ack_i = 1'b0;
    flush_i = 1'b0;
    mem_ce_i = 1'b0;
    if_ce_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_ce_i = 1'b1; mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'hF;
    if_addr_i = $urandom; mem_addr_i = $urandom; mem_data_i = $urandom;
    flush_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = $urandom;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (stallreq_o !== 1'b0) begin
      n_err++; $display("FAIL reset_stall: got %0b, expected 0", stallreq_o);
    end
    n_vec++;
    if (bus_req_o !== 1'b0 || bus_we_o !== 1'b0 || bus_sel_o !== 4'h0) begin
      n_err++; $display("FAIL reset_bus_ctl: req=%0b we=%0b sel=%h, expected all 0", bus_req_o, bus_we_o, bus_sel_o);
    end
    n_vec++;
    if (bus_addr_o !== 32'h0 || bus_wdata_o !== 32'h0) begin
      n_err++; $display("FAIL reset_bus_dat: addr=%h wdata=%h, expected 0", bus_addr_o, bus_wdata_o);
    end
    n_vec++;
    if (if_data_o !== 32'h0 || mem_data_o !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata: if=%h mem=%h, expected 0", if_data_o, mem_data_o);
    end
    exp_if_data = '0; exp_mem_data = '0; exp_bus_addr = '0;
    @(negedge clk);
    if_ce_i = 1'b0; mem_ce_i = 1'b0; bus_ack_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch_only();
    run_op(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h0000_0100, 0, 0, -1, 32'h0,
           32'h2401_0005, 32'h0, "fetch_only");
  endtask

  task automatic test_lw_and_fetch();
    run_op(1, 0, 4'hF, 32'h0000_0080, 32'h0, 1, 32'h0000_0104, 0, 0, -1, 32'h0,
           32'h1111_1111, 32'h2222_2222, "lw_and_fetch");
  endtask

  task automatic test_sw_wait();
    run_op(1, 1, 4'b0011, 32'h0000_0200, 32'hAABB_CCDD, 0, 32'h0, 2, 0, -1, 32'h0,
           32'h5555_AAAA, 32'h0, "sw_wait");
  endtask

  task automatic test_flush();
    run_op(1, 0, 4'hF, 32'h0000_0300, 32'h0, 1, 32'h0000_0108, 2, 1, 0, 32'hBFC0_0380,
           32'hDEAD_BEEF, 32'h0BAD_F00D, "flush_dbusy");
  endtask

  task automatic test_reset_busy();
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0400;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus_req_o !== 1'b1) begin
      n_err++; $display("FAIL rstbusy_req_before: got %0b, expected 1", bus_req_o);
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if (bus_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
      n_err++; $display("FAIL rstbusy_async: req=%0b stall=%0b, expected 0 0", bus_req_o, stallreq_o);
    end
    n_vec++;
    if (bus_addr_o !== 32'h0 || bus_sel_o !== 4'h0 || bus_we_o !== 1'b0 || bus_wdata_o !== 32'h0 ||
        if_data_o !== 32'h0 || mem_data_o !== 32'h0) begin
      n_err++; $display("FAIL rstbusy_outputs: addr=%h sel=%h we=%0b wd=%h if=%h mem=%h, expected all 0",
                        bus_addr_o, bus_sel_o, bus_we_o, bus_wdata_o, if_data_o, mem_data_o);
    end
    exp_if_data = '0; exp_mem_data = '0; exp_bus_addr = '0;
    @(negedge clk);
    if_ce_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_spurious_ack();
    for (int i = 0; i < 4; i++) begin
      if_ce_i = 1'b0; mem_ce_i = 1'b0;
      bus_ack_i = 1'b1; bus_rdata_i = $urandom;
      #1;
      n_vec++;
      if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0 || bus_addr_o !== exp_bus_addr ||
          if_data_o !== exp_if_data || mem_data_o !== exp_mem_data) begin
        n_err++;
        $display("FAIL spurious_ack%0d: stall=%0b req=%0b addr=%h if=%h mem=%h, expected 0 0 %h %h %h",
                 i, stallreq_o, bus_req_o, bus_addr_o, if_data_o, mem_data_o,
                 exp_bus_addr, exp_if_data, exp_mem_data);
      end
      @(negedge clk);
    end
    bus_ack_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      bit dm, di, we;
      int wd, wi, fa;
      dm = 1'($urandom_range(0, 1));
      di = 1'($urandom_range(0, 1));
      if (!dm && !di) di = 1;
      we = 1'($urandom_range(0, 1));
      fa = -1;
      if (dm && di && $urandom_range(0, 3) == 0) begin
        wd = $urandom_range(1, 3);
        fa = $urandom_range(0, wd - 1);
      end else begin
        wd = $urandom_range(0, 3);
      end
      wi = $urandom_range(0, 3);
      run_op(dm, we, 4'($urandom_range(1, 15)), {$urandom_range(0, 65535), 2'b00} & 32'h0003_FFFC,
             $urandom, di, {$urandom_range(0, 65535), 2'b00} & 32'h0003_FFFC, wd, wi, fa,
             32'hBFC0_0380, $urandom, $urandom, "random_op");
      // Occasionally leave the bus idle for a few cycles between groups.
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0;
    if_ce_i = 1'b0; if_addr_i = '0;
    mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = '0; mem_addr_i = '0; mem_data_i = '0;
    flush_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = '0;
    exp_if_data = '0; exp_mem_data = '0; exp_bus_addr = '0;
    test_reset();
    test_fetch_only();
    test_lw_and_fetch();
    test_sw_wait();
    test_flush();
    test_spurious_ack();
    test_back_to_back();
    test_reset_busy();
    test_spurious_ack();
    test_lw_and_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single unified memory bus port between the instruction-fetch port and the MEM-stage data port. It serialises the two ports into one bus transaction at a time, with data priority, and raises a stall request to `ctrl` until every pending access has completed. Read data is latched and presented in a one-cycle release window so the pipeline can advance. It sits between the pipeline (`pc_reg`/`if` and `mem`) and the external SRAM/bus controller.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset: asynchronous, active-low
- `if_ce_i`  in  1  fetch request (level, held while stalled)
- `if_addr_i`  in  AW  fetch address
- `if_data_o`  out  DW  fetched instruction, valid in RELEASE
- `mem_ce_i`  in  1  data request (level, held while stalled)
- `mem_we_i`  in  1  1 = write (already masked by exception in `mem`)
- `mem_sel_i`  in  4  byte enables
- `mem_addr_i`  in  AW  data address
- `mem_data_i`  in  DW  write data
- `mem_data_o`  out  DW  read data, valid in RELEASE
- `flush_i`  in  1  pipeline flush from `ctrl` (exception/eret)
- `stallreq_o`  out  1  stall request to `ctrl`
- `bus_req_o`  out  1  bus request, held until ack
- `bus_we_o`  out  1  bus write
- `bus_sel_o`  out  4  bus byte enables
- `bus_addr_o`  out  AW  bus address
- `bus_wdata_o`  out  DW  bus write data
- `bus_ack_i`  in  1  one-cycle completion strobe
- `bus_rdata_i`  in  DW  read data, valid with ack

## Operation
- FSM states: IDLE, D_BUSY, I_BUSY, RELEASE. An `if_pend` flag marks a fetch owed after a data access. An `abort` flag marks a flushed transaction.
- IDLE:
  - If `mem_ce_i`=1, latch the data request onto the bus outputs and go to D_BUSY. Set `if_pend` = `if_ce_i`.
  - Else if `if_ce_i`=1, latch the fetch (we=0, sel=4'b1111) and go to I_BUSY.
  - Else stay in IDLE.
- D_BUSY / I_BUSY:
  - `bus_req_o`=1, and the bus outputs stay constant until `bus_ack_i`.
  - On ack in D_BUSY with `if_pend`=1 and `abort`=0: capture `mem_data_o` (reads only; writes leave it unchanged), clear `if_pend`, latch the fetch, and go to I_BUSY.
  - On ack otherwise: capture the read data into the matching output register and go to RELEASE. If `abort`=1, go to IDLE and discard the data instead.
- RELEASE:
  - `stallreq_o`=0. The data outputs stay valid.
  - No bus request is launched, even though the requests are still asserted.
  - Next state is always IDLE.
- `stallreq_o` is combinational: (`if_ce_i` | `mem_ce_i` | state∈{D_BUSY, I_BUSY}) & state≠RELEASE & ~(state==IDLE & `flush_i`).
- Flush handling:
  - A flush in IDLE starts nothing that cycle.
  - A flush during BUSY never cuts the bus transaction short. It sets `abort` and clears `if_pend`. The arbiter waits for ack, then goes to IDLE with no RELEASE.
  - `abort` clears on entry to IDLE.
- `bus_ack_i` outside the BUSY states is ignored.
- Data priority is absolute. A fetch is never started while `mem_ce_i`=1 in IDLE.

## Timing
- Reset (`rst`=0, asynchronous) puts the block in IDLE:
  - `if_pend`=0 and `abort`=0.
  - `bus_req_o`, `bus_we_o`, `bus_sel_o`, `bus_addr_o`, `bus_wdata_o`, `if_data_o` and `mem_data_o` are all 0.
  - `stallreq_o` is 0 while `rst`=0.
- A reset mid-transaction abandons the access immediately; `bus_req_o` drops asynchronously.
- Bus outputs are registered. `bus_req_o` rises the cycle after the request is seen in IDLE.
- Single access with ack in the first BUSY cycle: stall high for 2 cycles (IDLE, BUSY), RELEASE in cycle 3. Each added bus wait cycle adds one stall cycle.
- Data + fetch with both acks immediate: IDLE, D_BUSY, I_BUSY, RELEASE; stall high for 3 cycles.
- Back-to-back accesses: a minimum of one IDLE cycle follows each RELEASE.

## Test plan
- Fetch only: `if_ce_i`=1, addr 0x00000100, ack in the 1st BUSY cycle with rdata 0x24010005 -> `bus_req_o` high in cycle 1, `stallreq_o`=1,1,0, `if_data_o`=0x24010005 in RELEASE.
- Concurrent lw and fetch: data addr 0x80, fetch addr 0x104, rdata 0x11111111 then 0x22222222 -> bus addr 0x80 first, then 0x104. `mem_data_o`=0x11111111, `if_data_o`=0x22222222, stall low only in RELEASE.
- sw with wait states: sel 4'b0011, data 0xAABBCCDD, ack after 3 cycles -> bus outputs stable for all 3 cycles, `bus_we_o`=1, 4 stall cycles, `mem_data_o` unchanged.
- Flush during D_BUSY with `if_pend`=1 -> ack completes the data access, no fetch issued, no RELEASE, next state IDLE.
- Reset asserted during I_BUSY -> `bus_req_o` falls without a clock edge, all outputs 0.
- Spurious `bus_ack_i` in IDLE with no requests -> no state change, outputs unchanged.
